// File: rtl/register_8bit_pkg.sv
// Shared defaults for the byte register slice.
// Exports: DEF_WIDTH, DEF_CLR_VALUE.
package register_8bit_pkg;

    localparam int          DEF_WIDTH     = 8;
    localparam logic [7:0]  DEF_CLR_VALUE = 8'h00;

endpackage

// File: rtl/register_8bit_dff_en_clr.sv
// 1-bit flop: sync active-high clear, active-low load enable.
// Ports: clk, clr, en_ (0=load), d in; q registered out.
module dff_en_clr #(
    parameter logic CLR_BIT = 1'b0
) (
    input  logic clk,
    input  logic clr,
    input  logic en_,
    input  logic d,
    output logic q
);

    // Clear has priority over load; en_ high holds.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= CLR_BIT;
        end else if (!en_) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_8bit.sv
// Parallel-load register with sync clear and active-low enable.
// Ports: clk, clr, en_ (0=load), D[WIDTH] in; Z[WIDTH] out.
module register_8bit
    import register_8bit_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en_,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Z
);

    // One flop per bit, each with its own clear bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_en_clr #(
            .CLR_BIT (CLR_VALUE[i])
        ) u_ff (
            .clk (clk),
            .clr (clr),
            .en_ (en_),
            .d   (D[i]),
            .q   (Z[i])
        );
    end

endmodule

// File: tb/tb_register_8bit.sv
// Self-checking bench for register_8bit.
// Directed test plan followed by random cycles.
module tb_register_8bit;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       en_ = 1'b1;
    logic [7:0] d   = 8'h00;
    logic [7:0] z;

    logic [7:0] model_z = 8'hxx;
    int         checks  = 0;
    int         errors  = 0;

    register_8bit #(
        .WIDTH     (8),
        .CLR_VALUE (8'h00)
    ) dut (
        .clk (clk),
        .clr (clr),
        .en_ (en_),
        .D   (d),
        .Z   (z)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] exp);
        checks++;
        assert (z === exp) else begin
            errors++;
            $error("FAIL %s: Z=%h expected %h", tag, z, exp);
        end
    endtask

    // One rising edge: the model samples what the register
    // sees at the edge, then Z is checked at the falling edge.
    task automatic tick(input string tag);
        @(posedge clk);
        if (clr)
            model_z = 8'h00;
        else if (!en_)
            model_z = d;
        @(negedge clk);
        chk(tag, model_z);
    endtask

    initial begin
        @(negedge clk);

        // Clear from unknown
        d = 8'h00; en_ = 1'b1; clr = 1'b1;
        tick("clear_from_x");
        clr = 1'b0;
        tick("hold_zero_1");
        tick("hold_zero_2");

        // Load and hold
        d = 8'hAA; en_ = 1'b0;
        tick("load_aa");
        en_ = 1'b1; d = 8'h55;
        tick("hold_aa_1");
        tick("hold_aa_2");

        // Clear over held data, then reload
        clr = 1'b1;
        tick("clear_held");
        clr = 1'b0; d = 8'hCC; en_ = 1'b0;
        tick("load_cc");

        // Priority: clear beats load
        clr = 1'b1; en_ = 1'b0; d = 8'hFF;
        tick("clr_over_load");
        // Load follows on first edge with clr low
        clr = 1'b0; d = 8'hCC;
        tick("load_after_clr");

        // Mid-cycle enable
        en_ = 1'b1; d = 8'hFF;
        tick("hold_cc_pre");
        #2 en_ = 1'b0;
        #1 chk("midcycle_en_stable", 8'hCC);
        tick("midcycle_load_ff");
        tick("reload_ff_1");
        tick("reload_ff_2");

        // No combinational path D->Z
        en_ = 1'b0;
        #1 d = 8'h11;
        chk("nocomb_1", model_z);
        #1 d = 8'h22;
        chk("nocomb_2", model_z);
        #1 d = 8'h33;
        chk("nocomb_3", model_z);
        tick("nocomb_edge");

        // Random cycles with glitches between edges
        for (int i = 0; i < 300; i++) begin
            clr = ($urandom_range(0, 9) == 0);
            en_ = $urandom_range(0, 1) == 1;
            d   = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                #1 d = 8'($urandom);
                en_ = ~en_;
                #1 chk("rand_glitch", model_z);
                en_ = ~en_;
            end
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
